// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable multi-channel clock divider.
//
// Contents:
//   mode_t        2-bit channel mode encoding
//   MODE_*        OFF / TOGGLE / PULSE / ONESHOT mode values
//   ch_w(n)       width of a channel-select field for n channels (at least 1 bit)
package clk_div_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF     = 2'b00;
    localparam mode_t MODE_TOGGLE  = 2'b01;
    localparam mode_t MODE_PULSE   = 2'b10;
    localparam mode_t MODE_ONESHOT = 2'b11;

    // A single channel still needs a one-bit select port, so clamp at 1.
    function automatic int ch_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, active and shadow configuration,
// pending/done bookkeeping.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_reset    synchronous active-high reset
//   i_enable   count enable for this channel
//   i_wr       config write strobe already decoded for this channel
//   i_wrDiv    new divisor
//   i_wrMode   new mode
//   o_q        TOGGLE square wave, or a copy of the tick in PULSE/ONESHOT
//   o_tick     one-cycle pulse after each terminal count
//   o_pending  a written config is waiting for the next terminal count
//   o_done     ONESHOT has fired; cleared by the next applied write
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int                   CNT_WIDTH    = 23,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_DIV  = '1,
    parameter mode_t                DEFAULT_MODE = MODE_TOGGLE
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_wr,
    input  logic [CNT_WIDTH-1:0] i_wrDiv,
    input  mode_t                i_wrMode,
    output logic                 o_q,
    output logic                 o_tick,
    output logic                 o_pending,
    output logic                 o_done
);

    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] r_div;
    logic [CNT_WIDTH-1:0] r_shDiv;
    mode_t                r_mode;
    mode_t                r_shMode;
    logic                 r_q;
    logic                 r_tick;
    logic                 r_pending;
    logic                 r_done;

    logic                 w_idle;
    logic                 w_term;
    logic                 w_applyNow;
    logic                 w_applyTerm;
    logic [CNT_WIDTH-1:0] w_newDiv;
    mode_t                w_newMode;

    // An idle channel (OFF, or a ONESHOT that already fired) has no period
    // boundary to wait for, so a write to it can be taken on the next edge.
    assign w_idle      = (r_mode == MODE_OFF) || ((r_mode == MODE_ONESHOT) && r_done);
    assign w_term      = i_enable && !w_idle && (r_count == r_div);
    assign w_applyNow  = i_wr && w_idle;
    // A write arriving on the terminal edge itself wins over an older shadow value.
    assign w_applyTerm = w_term && (i_wr || r_pending);
    assign w_newDiv    = i_wr ? i_wrDiv  : r_shDiv;
    assign w_newMode   = i_wr ? i_wrMode : r_shMode;

    // Counting and output generation use the old config first; a config
    // apply on the same edge then overrides count/Q/pending/done so the new
    // settings start cleanly from the following cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count   <= '0;
            r_div     <= DEFAULT_DIV;
            r_mode    <= DEFAULT_MODE;
            r_shDiv   <= DEFAULT_DIV;
            r_shMode  <= DEFAULT_MODE;
            r_q       <= 1'b0;
            r_tick    <= 1'b0;
            r_pending <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (w_term) begin
                r_count <= '0;
                r_tick  <= 1'b1;
                r_q     <= (r_mode == MODE_TOGGLE) ? ~r_q : 1'b1;
                if (r_mode == MODE_ONESHOT) begin
                    r_done <= 1'b1;
                end
            end else begin
                if (i_enable && !w_idle) begin
                    r_count <= r_count + CNT_WIDTH'(1);
                end
                // Outside TOGGLE, Q mirrors tick, which is low on non-terminal edges.
                if (r_mode != MODE_TOGGLE) begin
                    r_q <= 1'b0;
                end
            end

            if (w_applyNow) begin
                r_div     <= i_wrDiv;
                r_mode    <= i_wrMode;
                r_count   <= '0;
                r_q       <= 1'b0;
                r_done    <= 1'b0;
                r_pending <= 1'b0;
            end else if (w_applyTerm) begin
                r_div     <= w_newDiv;
                r_mode    <= w_newMode;
                r_pending <= 1'b0;
                r_done    <= 1'b0;
                // A square wave carries on seamlessly only when staying in TOGGLE.
                if (!((w_newMode == MODE_TOGGLE) && (r_mode == MODE_TOGGLE))) begin
                    r_q <= 1'b0;
                end
                if (w_newMode == MODE_OFF) begin
                    r_tick <= 1'b0;
                end
            end else if (i_wr) begin
                r_shDiv   <= i_wrDiv;
                r_shMode  <= i_wrMode;
                r_pending <= 1'b1;
            end
        end
    end

    assign o_q       = r_q;
    assign o_tick    = r_tick;
    assign o_pending = r_pending;
    assign o_done    = r_done;

endmodule

// File: rtl/clk_divider_prog_multi.sv
// NUM_CH independent runtime-programmable clock dividers on one system clock.
// Each channel runs OFF, TOGGLE (square wave), PULSE (periodic tick) or
// ONESHOT; config changes land at period boundaries.
//
// Ports:
//   Clk      system clock, rising edge
//   reset    synchronous active-high, clears every channel
//   enable   per-channel count enable
//   wr_en    config write strobe (one channel per cycle)
//   wr_ch    target channel; values >= NUM_CH are ignored
//   wr_div   new divisor D (period is D+1 enabled cycles)
//   wr_mode  new mode: 00 OFF, 01 TOGGLE, 10 PULSE, 11 ONESHOT
//   Q        per-channel divided output
//   tick     per-channel one-cycle terminal pulse
//   pending  per-channel written-but-not-applied flag
//   done     per-channel sticky ONESHOT-fired flag
module clk_divider_prog_multi
    import clk_div_pkg::*;
#(
    parameter int                   NUM_CH       = 4,
    parameter int                   CNT_WIDTH    = 23,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_DIV  = 23'h2625A0,
    parameter mode_t                DEFAULT_MODE = MODE_TOGGLE,
    localparam int                  CH_W         = ch_w(NUM_CH)
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    enable,
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [CNT_WIDTH-1:0] wr_div,
    input  mode_t                wr_mode,
    output logic [NUM_CH-1:0]    Q,
    output logic [NUM_CH-1:0]    tick,
    output logic [NUM_CH-1:0]    pending,
    output logic [NUM_CH-1:0]    done
);

    logic [NUM_CH-1:0] w_chWr;

    // Out-of-range channel numbers match no strobe, so they change nothing.
    for (genvar g = 0; g < NUM_CH; g++) begin : gCh
        assign w_chWr[g] = wr_en && (wr_ch == CH_W'(g));

        clk_div_channel #(
            .CNT_WIDTH   (CNT_WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV),
            .DEFAULT_MODE(DEFAULT_MODE)
        ) uChan (
            .i_clk    (Clk),
            .i_reset  (reset),
            .i_enable (enable[g]),
            .i_wr     (w_chWr[g]),
            .i_wrDiv  (wr_div),
            .i_wrMode (wr_mode),
            .o_q      (Q[g]),
            .o_tick   (tick[g]),
            .o_pending(pending[g]),
            .o_done   (done[g])
        );
    end

endmodule

// File: tb/tb_clk_divider_prog_multi.sv
// Directed bench for clk_divider_prog_multi with NUM_CH=4, CNT_WIDTH=8.
// A second 5-channel instance provides a 3-bit wr_ch so that an
// out-of-range channel number can actually be presented.
module tb_clk_divider_prog_multi;
    import clk_div_pkg::*;

    timeunit 1ns;
    timeprecision 1ps;

    logic       Clk = 1'b0;
    logic       reset;
    logic [3:0] enable;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_div;
    mode_t      wr_mode;
    logic [3:0] Q;
    logic [3:0] tick;
    logic [3:0] pending;
    logic [3:0] done;

    logic [4:0] enable5;
    logic       wrEn5;
    logic [2:0] wrCh5;
    logic [4:0] q5;
    logic [4:0] tick5;
    logic [4:0] pending5;
    logic [4:0] done5;

    int checkCount = 0;
    int failCount  = 0;

    always #5 Clk = ~Clk;

    clk_divider_prog_multi #(
        .NUM_CH      (4),
        .CNT_WIDTH   (8),
        .DEFAULT_DIV (8'd10),
        .DEFAULT_MODE(MODE_OFF)
    ) uDut (
        .Clk    (Clk),
        .reset  (reset),
        .enable (enable),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
        .wr_mode(wr_mode),
        .Q      (Q),
        .tick   (tick),
        .pending(pending),
        .done   (done)
    );

    clk_divider_prog_multi #(
        .NUM_CH      (5),
        .CNT_WIDTH   (8),
        .DEFAULT_DIV (8'd10),
        .DEFAULT_MODE(MODE_OFF)
    ) uDut5 (
        .Clk    (Clk),
        .reset  (reset),
        .enable (enable5),
        .wr_en  (wrEn5),
        .wr_ch  (wrCh5),
        .wr_div (wr_div),
        .wr_mode(wr_mode),
        .Q      (q5),
        .tick   (tick5),
        .pending(pending5),
        .done   (done5)
    );

    // Advance n rising edges and land 1 ns past the last one for sampling.
    task automatic stepCycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // One-cycle config write to the 4-channel instance.
    task automatic applyStimulus(input logic [1:0] ch, input logic [7:0] div, input mode_t mode);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_div  = div;
        wr_mode = mode;
        stepCycles(1);
        wr_en   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] qv16, tv16;
        logic [19:0] qv20, tv20;
        logic [11:0] qv12, tv12, pv12, dv12;
        logic [5:0]  tv6, dv6;
        logic [3:0]  tv4;
        logic [4:0]  acc5;
        logic [3:0]  accT, accQ;
        int firstTick, secondTick;
        logic qAt300, qAt520;

        reset   = 1'b1;
        enable  = '0;
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_div  = '0;
        wr_mode = MODE_OFF;
        enable5 = '0;
        wrEn5   = 1'b0;
        wrCh5   = '0;
        stepCycles(3);
        checkOutput("reset_Q",       32'(Q),       32'h0);
        checkOutput("reset_tick",    32'(tick),    32'h0);
        checkOutput("reset_pending", 32'(pending), 32'h0);
        checkOutput("reset_done",    32'(done),    32'h0);
        reset = 1'b0;
        stepCycles(1);

        // ch0 TOGGLE D=3 from OFF: tick every 4 cycles, Q period 8.
        applyStimulus(2'd0, 8'd3, MODE_TOGGLE);
        enable[0] = 1'b1;
        checkOutput("t1_pending0", 32'(pending[0]), 32'h0);
        for (int k = 1; k <= 16; k++) begin
            stepCycles(1);
            qv16[k-1] = Q[0];
            tv16[k-1] = tick[0];
        end
        checkOutput("t1_tick0_seq", 32'(tv16), 32'h8888);
        checkOutput("t1_q0_seq",    32'(qv16), 32'h7878);

        // ch1 PULSE D=4 with enable low over cycles 13..15: ticks at 5, 10, 18.
        applyStimulus(2'd1, 8'd4, MODE_PULSE);
        for (int k = 1; k <= 20; k++) begin
            enable[1] = !(k >= 13 && k <= 15);
            stepCycles(1);
            qv20[k-1] = Q[1];
            tv20[k-1] = tick[1];
        end
        enable[1] = 1'b0;
        checkOutput("t2_tick1_seq", 32'(tv20), 32'h20210);
        checkOutput("t2_q1_seq",    32'(qv20), 32'h20210);

        // ch2 TOGGLE D=9, rewrite D=2 when count=3: old-D terminal 6 cycles later, then period 3.
        applyStimulus(2'd2, 8'd9, MODE_TOGGLE);
        enable[2] = 1'b1;
        stepCycles(3);
        applyStimulus(2'd2, 8'd2, MODE_TOGGLE);
        checkOutput("t3_pending2_set", 32'(pending[2]), 32'h1);
        for (int k = 1; k <= 12; k++) begin
            stepCycles(1);
            tv12[k-1] = tick[2];
            qv12[k-1] = Q[2];
            pv12[k-1] = pending[2];
        end
        enable[2] = 1'b0;
        checkOutput("t3_tick2_seq",    32'(tv12), 32'h920);
        checkOutput("t3_q2_seq",       32'(qv12), 32'h8E0);
        checkOutput("t3_pending2_seq", 32'(pv12), 32'h01F);

        // ch3 ONESHOT D=5: one tick at cycle 6, done sticky, then re-arm with D=1.
        applyStimulus(2'd3, 8'd5, MODE_ONESHOT);
        enable[3] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            stepCycles(1);
            tv12[k-1] = tick[3];
            qv12[k-1] = Q[3];
            dv12[k-1] = done[3];
        end
        checkOutput("t4_tick3_seq", 32'(tv12), 32'h020);
        checkOutput("t4_q3_seq",    32'(qv12), 32'h020);
        checkOutput("t4_done3_seq", 32'(dv12), 32'hFE0);
        applyStimulus(2'd3, 8'd1, MODE_ONESHOT);
        checkOutput("t4_rearm_done3",    32'(done[3]),    32'h0);
        checkOutput("t4_rearm_pending3", 32'(pending[3]), 32'h0);
        for (int k = 1; k <= 6; k++) begin
            stepCycles(1);
            tv6[k-1] = tick[3];
            dv6[k-1] = done[3];
        end
        checkOutput("t4_rearm_tick3_seq", 32'(tv6), 32'h02);
        checkOutput("t4_rearm_done3_seq", 32'(dv6), 32'h3E);

        // ch1 held at count 2 (PULSE D=4); two enabled cycles bring it to 4,
        // so the write lands exactly on the terminal edge.
        enable[1] = 1'b1;
        stepCycles(2);
        checkOutput("t5_pre_term_tick1", 32'(tick[1]), 32'h0);
        applyStimulus(2'd1, 8'd1, MODE_PULSE);
        checkOutput("t5_term_tick1",    32'(tick[1]),    32'h1);
        checkOutput("t5_term_pending1", 32'(pending[1]), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            stepCycles(1);
            tv4[k-1] = tick[1];
        end
        checkOutput("t5_newcfg_tick1_seq", 32'(tv4), 32'hA);

        // Leave a pending write on disabled ch2, then reset over it.
        applyStimulus(2'd2, 8'd0, MODE_PULSE);
        checkOutput("t5_pending2_before_reset", 32'(pending[2]), 32'h1);
        reset = 1'b1;
        stepCycles(1);
        reset = 1'b0;
        checkOutput("t5_rst_Q",       32'(Q),       32'h0);
        checkOutput("t5_rst_tick",    32'(tick),    32'h0);
        checkOutput("t5_rst_pending", 32'(pending), 32'h0);
        checkOutput("t5_rst_done",    32'(done),    32'h0);
        enable = 4'hF;
        accT = '0;
        accQ = '0;
        for (int k = 1; k <= 12; k++) begin
            stepCycles(1);
            accT |= tick;
            accQ |= Q;
        end
        checkOutput("t5_default_off_tick", 32'(accT), 32'h0);
        checkOutput("t5_default_off_Q",    32'(accQ), 32'h0);

        // Out-of-range channel on the 5-channel instance is ignored; channel 4 is not.
        enable5 = 5'h1F;
        wr_div  = 8'd0;
        wr_mode = MODE_PULSE;
        wrEn5   = 1'b1;
        wrCh5   = 3'd5;
        stepCycles(1);
        wrCh5   = 3'd7;
        stepCycles(1);
        wrEn5   = 1'b0;
        acc5    = '0;
        for (int k = 1; k <= 4; k++) begin
            stepCycles(1);
            acc5 |= tick5 | pending5 | q5 | done5;
        end
        checkOutput("t5_badch_no_change", 32'(acc5), 32'h0);
        wrEn5 = 1'b1;
        wrCh5 = 3'd4;
        stepCycles(1);
        wrEn5 = 1'b0;
        stepCycles(2);
        checkOutput("t5_ch4_tick", 32'(tick5), 32'h10);

        // D=0 PULSE: tick stays high while enabled, drops once disabled.
        applyStimulus(2'd0, 8'd0, MODE_PULSE);
        for (int k = 1; k <= 6; k++) begin
            stepCycles(1);
            tv6[k-1] = tick[0];
        end
        checkOutput("t6_d0_tick0_seq", 32'(tv6), 32'h3F);
        enable[0] = 1'b0;
        stepCycles(1);
        checkOutput("t6_d0_disabled_tick0", 32'(tick[0]), 32'h0);

        // D=255 TOGGLE: half period 256 cycles without counter overflow.
        applyStimulus(2'd1, 8'd255, MODE_TOGGLE);
        firstTick  = 0;
        secondTick = 0;
        qAt300     = 1'b0;
        qAt520     = 1'b1;
        for (int k = 1; k <= 520; k++) begin
            stepCycles(1);
            if (tick[1]) begin
                if (firstTick == 0) firstTick = k;
                else if (secondTick == 0) secondTick = k;
            end
            if (k == 300) qAt300 = Q[1];
            if (k == 520) qAt520 = Q[1];
        end
        checkOutput("t6_d255_first_tick",  32'(firstTick),  32'd256);
        checkOutput("t6_d255_second_tick", 32'(secondTick), 32'd512);
        checkOutput("t6_d255_q_at_300",    32'(qAt300),     32'h1);
        checkOutput("t6_d255_q_at_520",    32'(qAt520),     32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
